write_buffer: RTL

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/write_buffer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/write_buffer.sv
// write_buffer: one-entry dirty-victim buffer between cache and physical memory.
// Define WRITE_BUFFER_FWD_EN to serve fills that hit the buffered line directly.
module write_buffer (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cache_read,
  input  logic [15:0]  cache_address,
  output logic [127:0] cache_rdata,
  output logic         cache_resp,
  input  logic         wb_valid,
  input  logic [15:0]  wb_address,
  input  logic [127:0] wb_wdata,
  output logic         wb_ready,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

  state_e       state_q, state_d;
  logic         buf_valid_q, buf_valid_d;
  logic [11:0]  buf_tag_q, buf_tag_d;
  logic [127:0] buf_data_q, buf_data_d;
  logic [127:0] rdata_q, rdata_d;
  logic         hit;
  logic         capture;
  logic         unused_lsbs;

  // Hit only against the registered entry, never a same-edge capture.
  assign hit = buf_valid_q
            && (cache_address[15:4] == buf_tag_q);
  assign capture = wb_valid && !buf_valid_q;
  assign unused_lsbs = ^{cache_address[3:0],
                         wb_address[3:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cache_read) begin
          if (hit) begin
`ifdef WRITE_BUFFER_FWD_EN
            state_d = RESP;
`else
            state_d = WRITE;
`endif
          end else begin
            state_d = READ;
          end
        end else if (buf_valid_q) begin
          state_d = WRITE;
        end
      end
      READ:    if (pmem_resp) state_d = RESP;
      WRITE:   if (pmem_resp) state_d = IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    rdata_d     = rdata_q;
    if (state_q == WRITE && pmem_resp) begin
      buf_valid_d = 1'b0;
    end
    if (capture) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = wb_address[15:4];
      buf_data_d  = wb_wdata;
    end
    if (state_q == READ && pmem_resp) begin
      rdata_d = pmem_rdata;
    end
`ifdef WRITE_BUFFER_FWD_EN
    if (state_q == IDLE && cache_read && hit) begin
      rdata_d = buf_data_q;
    end
`endif
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    cache_resp   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state_q)
      READ: begin
        pmem_read    = 1'b1;
        pmem_address = {cache_address[15:4], 4'h0};
      end
      WRITE: begin
        pmem_write   = 1'b1;
        pmem_address = {buf_tag_q, 4'h0};
        pmem_wdata   = buf_data_q;
      end
      RESP:    cache_resp = 1'b1;
      default: ;
    endcase
  end

  assign wb_ready    = !buf_valid_q;
  assign cache_rdata = rdata_q;

endmodule
